// File: rtl/icache_fetch.sv
// Direct-mapped one-word-per-line instruction cache between fetch and MemCtrl.
// Latency: hit returns one cycle after accept; miss returns one cycle after mc_done.
// Backpressure: if_ready low while a refill is outstanding; rdy low freezes everything.
module icache_fetch #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_BITS  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_done,
    input  logic [31:0] mc_data
);
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                state, state_nxt;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_arr  [LINES];
    logic [31:0]           data_arr [LINES];
    logic [31:0]           miss_pc;
    logic                  cancel, cancel_nxt;
    logic                  accept, fill, vld_nxt, req_nxt, hit;

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_BITS-1:0]   req_tag, fill_tag;

    assign req_idx  = if_pc[INDEX_BITS+1:2];
    assign req_tag  = if_pc[ADDR_BITS-1:INDEX_BITS+2];
    assign fill_idx = miss_pc[INDEX_BITS+1:2];
    assign fill_tag = miss_pc[ADDR_BITS-1:INDEX_BITS+2];
    assign hit      = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign if_ready = (state == IDLE);

    always_comb begin
        state_nxt  = state;
        cancel_nxt = cancel;
        accept     = 1'b0;
        fill       = 1'b0;
        vld_nxt    = 1'b0;
        req_nxt    = mc_req;
        case (state)
            IDLE: begin
                accept = if_req && !flush;
                if (accept && hit) begin
                    vld_nxt = 1'b1;
                end else if (accept) begin
                    state_nxt = MISS;
                    req_nxt   = 1'b1;
                end
            end
            MISS: begin
                // MemCtrl cannot abort, so a flush only suppresses delivery.
                if (mc_done) begin
                    fill       = 1'b1;
                    state_nxt  = IDLE;
                    req_nxt    = 1'b0;
                    vld_nxt    = !(cancel || flush);
                    cancel_nxt = 1'b0;
                end else begin
                    cancel_nxt = cancel || flush;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid_q    <= '0;
            cancel     <= 1'b0;
            miss_pc    <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            mc_req     <= 1'b0;
            mc_addr    <= '0;
        end else if (rdy) begin
            state      <= state_nxt;
            cancel     <= cancel_nxt;
            inst_valid <= vld_nxt;
            mc_req     <= req_nxt;
            if (accept && hit) begin
                inst    <= data_arr[req_idx];
                inst_pc <= if_pc;
            end else if (accept) begin
                miss_pc <= if_pc;
                mc_addr <= {if_pc[31:2], 2'b00};
            end
            if (fill) begin
                valid_q[fill_idx] <= 1'b1;
                if (vld_nxt) begin
                    inst    <= mc_data;
                    inst_pc <= miss_pc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= mc_data;
        end
    end
endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: directed scenarios then randomized fetches against a line-content model.
module tb_icache_fetch;
    logic        clk = 1'b0;
    logic        rst, rdy, flush, if_req, mc_done;
    logic [31:0] if_pc, mc_data;
    logic        if_ready, inst_valid, mc_req;
    logic [31:0] inst, inst_pc, mc_addr;

    int nvec = 0;
    int nerr = 0;

    // Model: which word address each line holds, and that word's value.
    bit          lv   [64];
    logic [15:0] lwa  [64];
    logic [31:0] ldat [64];
    logic [31:0] mem  [int];

    icache_fetch dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_req(if_req), .if_pc(if_pc), .if_ready(if_ready),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .mc_req(mc_req), .mc_addr(mc_addr), .mc_done(mc_done), .mc_data(mc_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] pc);
        int wa;
        wa = int'(pc[17:2]);
        if (!mem.exists(wa)) mem[wa] = $urandom;
        return mem[wa];
    endfunction

    function automatic void mem_wr(input logic [31:0] pc, input logic [31:0] d);
        mem[int'(pc[17:2])] = d;
    endfunction

    // One request; a miss is serviced after stall rdy-low cycles and lat wait cycles.
    // flush_cyc >= 0 pulses flush that many cycles into the miss (lat means with mc_done).
    task automatic fetch(input logic [31:0] pc, input int lat, input int flush_cyc, input int stall);
        int          idx;
        bit          hit;
        logic [31:0] d;
        idx = int'(pc[7:2]);
        hit = lv[idx] && (lwa[idx] == pc[17:2]);
        chk("ready_pre", {31'd0, if_ready}, 32'd1);
        if_req = 1'b1;
        if_pc  = pc;
        step();
        if_req = 1'b0;
        if_pc  = $urandom;
        if (hit) begin
            chk("hit_vld", {31'd0, inst_valid}, 32'd1);
            chk("hit_inst", inst, ldat[idx]);
            chk("hit_pc", inst_pc, pc);
            chk("hit_noreq", {31'd0, mc_req}, 32'd0);
        end else begin
            chk("miss_vld", {31'd0, inst_valid}, 32'd0);
            chk("miss_req", {31'd0, mc_req}, 32'd1);
            chk("miss_addr", mc_addr, {pc[31:2], 2'b00});
            chk("miss_busy", {31'd0, if_ready}, 32'd0);
            if (stall > 0) begin
                rdy = 1'b0;
                repeat (stall) step();
                chk("stall_req", {31'd0, mc_req}, 32'd1);
                chk("stall_addr", mc_addr, {pc[31:2], 2'b00});
                chk("stall_busy", {31'd0, if_ready}, 32'd0);
                rdy = 1'b1;
            end
            for (int c = 0; c < lat; c++) begin
                flush = (c == flush_cyc);
                step();
            end
            flush = 1'b0;
            if (lat > 0) chk("hold_req", {31'd0, mc_req}, 32'd1);
            flush   = (lat == flush_cyc);
            d       = mem_rd(pc);
            mc_done = 1'b1;
            mc_data = d;
            step();
            mc_done = 1'b0;
            flush   = 1'b0;
            mc_data = $urandom;
            lv[idx]   = 1'b1;
            lwa[idx]  = pc[17:2];
            ldat[idx] = d;
            chk("fill_req0", {31'd0, mc_req}, 32'd0);
            chk("fill_ready", {31'd0, if_ready}, 32'd1);
            if (flush_cyc >= 0) begin
                chk("cancel_vld", {31'd0, inst_valid}, 32'd0);
            end else begin
                chk("fill_vld", {31'd0, inst_valid}, 32'd1);
                chk("fill_inst", inst, d);
                chk("fill_pc", inst_pc, pc);
            end
        end
        step();
        chk("vld_pulse", {31'd0, inst_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] pc;
        int          lat, fc, st;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; if_req = 1'b0;
        if_pc = '0; mc_done = 1'b0; mc_data = '0;
        for (int i = 0; i < 64; i++) lv[i] = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_vld", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_req", {31'd0, mc_req}, 32'd0);
        chk("rst_addr", mc_addr, 32'd0);
        chk("rst_ready", {31'd0, if_ready}, 32'd1);

        // First fill, preload, then back-to-back hits.
        mem_wr(32'h0, 32'h0000_0013);
        fetch(32'h0, 2, -1, 0);
        fetch(32'h4, 1, -1, 0);
        fetch(32'h0, 0, -1, 0);
        if_req = 1'b1; if_pc = 32'h0;
        step();
        chk("b2b_vld0", {31'd0, inst_valid}, 32'd1);
        chk("b2b_inst0", inst, 32'h0000_0013);
        if_pc = 32'h4;
        step();
        if_req = 1'b0;
        chk("b2b_vld1", {31'd0, inst_valid}, 32'd1);
        chk("b2b_inst1", inst, ldat[1]);
        chk("b2b_pc1", inst_pc, 32'h4);
        step();
        chk("b2b_end", {31'd0, inst_valid}, 32'd0);

        // Same index, different tag.
        mem_wr(32'h0, 32'h1111_1111);
        mem_wr(32'h100, 32'h2222_2222);
        fetch(32'h100, 1, -1, 0);
        fetch(32'h0, 1, -1, 0);
        fetch(32'h100, 2, -1, 0);
        fetch(32'h100, 0, -1, 0);
        fetch(32'h0, 1, -1, 0);

        // Flush during a miss; line still written. Stray mc_done in IDLE is ignored.
        mem_wr(32'h40, 32'hDEAD_BEEF);
        fetch(32'h40, 3, 2, 0);
        mc_done = 1'b1; mc_data = 32'hBAD0_BAD0;
        step();
        mc_done = 1'b0;
        chk("idle_done_vld", {31'd0, inst_valid}, 32'd0);
        fetch(32'h40, 0, -1, 0);

        // Request together with flush is refused.
        if_req = 1'b1; if_pc = 32'h40; flush = 1'b1;
        step();
        if_req = 1'b0; flush = 1'b0;
        chk("flush_idle_vld", {31'd0, inst_valid}, 32'd0);
        chk("flush_idle_req", {31'd0, mc_req}, 32'd0);

        // Flush coincident with mc_done.
        fetch(32'h44, 2, 2, 0);
        fetch(32'h44, 0, -1, 0);

        // rdy stall during a miss, then a held inst_valid across a stall.
        fetch(32'h80, 1, -1, 3);
        if_req = 1'b1; if_pc = 32'h80;
        step();
        if_req = 1'b0; rdy = 1'b0;
        step();
        step();
        chk("rdy_hold_vld", {31'd0, inst_valid}, 32'd1);
        chk("rdy_hold_inst", inst, ldat[32]);
        rdy = 1'b1;
        step();
        chk("rdy_release", {31'd0, inst_valid}, 32'd0);

        // Reset in the middle of a miss clears every line.
        if_req = 1'b1; if_pc = 32'h300;
        step();
        if_req = 1'b0;
        chk("rstmiss_req", {31'd0, mc_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmiss_req0", {31'd0, mc_req}, 32'd0);
        chk("rstmiss_ready", {31'd0, if_ready}, 32'd1);
        chk("rstmiss_addr", mc_addr, 32'd0);
        for (int i = 0; i < 64; i++) lv[i] = 1'b0;
        fetch(32'h0, 1, -1, 0);

        // Randomized fetches over a small address pool for hits and conflicts.
        for (int n = 0; n < 250; n++) begin
            pc = ({29'd0, 3'($urandom_range(0, 7))} << 8) | ({28'd0, 4'($urandom_range(0, 15))} << 2);
            if ($urandom_range(0, 1) == 1) pc = pc | ($urandom & 32'hFFFC_0000);
            lat = $urandom_range(0, 3);
            fc  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
            st  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
            fetch(pc, lat, fc, st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
